// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear controller for a BCD mm:ss counter chain
module stopwatch_ctrl #(
  parameter int DIV   = 50000000,
  parameter int CNT_W = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss,
  input  logic       key_clr,
  input  logic       key_lap,
  input  logic [6:0] sec_bcd,
  input  logic [6:0] min_bcd,
  input  logic       chain_co,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [6:0] disp_sec,
  output logic [6:0] disp_min,
  output logic [1:0] state,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(DIV - 1);

  // Key bit order everywhere: {lap, clr, ss}
  logic [2:0] key_raw;
  logic [2:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, pulse_q, pulse_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;

  logic ss_p, clr_p, lap_p, counting, clr_go;

  assign key_raw = {key_lap, key_clr, key_ss};
  assign ss_p    = pulse_q[0];
  assign clr_p   = pulse_q[1];
  assign lap_p   = pulse_q[2];

  // Two-flop synchroniser, then a registered rising-edge pulse per key
  always_comb begin
    s1_d    = key_raw;
    s2_d    = s1_q;
    s3_d    = s2_q;
    pulse_d = s2_q & ~s3_q;
  end

  // Next state, clear pulse, lap capture, prescaler, tick and wrap flag
  always_comb begin
    state_d   = state_q;
    clr_go    = 1'b0;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    counting  = (state_q == RUN) || (state_q == LAP);

    case (state_q)
      IDLE: begin
        if (clr_p) begin
          clr_go = 1'b1;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ss_p) begin
          state_d = PAUSE;
        end else if (lap_p) begin
          state_d   = LAP;
          lap_sec_d = sec_bcd;
          lap_min_d = min_bcd;
        end
      end
      LAP: begin
        if (ss_p) begin
          state_d = PAUSE;
        end else if (lap_p) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (clr_p) begin
          state_d = IDLE;
          clr_go  = 1'b1;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Prescaler keeps its partial count across a pause; only IDLE zeroes it
    if (state_q == IDLE) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end else begin
      presc_d = presc_q;
    end

    cnt_en_d  = counting && (presc_q == PRESC_MAX);
    cnt_clr_d = clr_go;

    if (clr_go) begin
      ovf_d = 1'b0;
    end else if (cnt_en_q && chain_co) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pulse_q   <= '0;
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
      lap_sec_q <= '0;
      lap_min_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pulse_q   <= pulse_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      ovf_q     <= ovf_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
    end
  end

  // Display follows the chain except while a lap time is frozen
  always_comb begin
    disp_sec = (state_q == LAP) ? lap_sec_q : sec_bcd;
    disp_min = (state_q == LAP) ? lap_min_q : min_bcd;
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign state   = state_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_ss, key_clr, key_lap;
  logic [6:0] sec_bcd, min_bcd;
  logic       chain_co;
  logic       cnt_en, cnt_clr, ovf;
  logic [6:0] disp_sec, disp_min;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_ctrl #(.DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .key_ss(key_ss), .key_clr(key_clr), .key_lap(key_lap),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .chain_co(chain_co),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .disp_sec(disp_sec), .disp_min(disp_min),
    .state(state), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise one key (0=ss 1=clr 2=lap); the FSM acts on the 4th edge, then release
  task automatic press(input int which);
    if (which == 0) key_ss = 1'b1;
    if (which == 1) key_clr = 1'b1;
    if (which == 2) key_lap = 1'b1;
    repeat (4) step();
    key_ss = 1'b0;
    key_clr = 1'b0;
    key_lap = 1'b0;
  endtask

  initial begin
    rst = 1'b0; key_ss = 1'b0; key_clr = 1'b0; key_lap = 1'b0;
    sec_bcd = 7'h12; min_bcd = 7'h03; chain_co = 1'b0;
    #2;
    check("rst_state", {5'd0, state}, 7'd0);
    check("rst_cnt_en", {6'd0, cnt_en}, 7'd0);
    check("rst_cnt_clr", {6'd0, cnt_clr}, 7'd0);
    check("rst_ovf", {6'd0, ovf}, 7'd0);
    check("rst_disp_sec", disp_sec, 7'h12);
    check("rst_disp_min", disp_min, 7'h03);
    step(); step();
    rst = 1'b1;
    step();

    // 1: start, key latency of three edges, tick every 4 cycles
    key_ss = 1'b1;
    step(); step(); step();
    check("ss_latency_pre", {5'd0, state}, 7'd0);
    step();
    check("ss_to_run", {5'd0, state}, 7'd1);
    key_ss = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("tick_k%0d", k), {6'd0, cnt_en}, (k % 4 == 0) ? 7'd1 : 7'd0);
      check($sformatf("noclr_k%0d", k), {6'd0, cnt_clr}, 7'd0);
    end

    // 2: pause with prescaler at 2, then resume
    press(0);
    check("pause", {5'd0, state}, 7'd2);
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("pause_quiet_%0d", k), {6'd0, cnt_en}, 7'd0);
    end
    press(0);
    check("resume", {5'd0, state}, 7'd1);
    step();
    check("resume_t1", {6'd0, cnt_en}, 7'd0);
    step();
    check("resume_t2", {6'd0, cnt_en}, 7'd1);

    // 3: lap freezes display at 01:25
    min_bcd = 7'h01; sec_bcd = 7'h25;
    step();
    press(2);
    check("lap_state", {5'd0, state}, 7'd3);
    sec_bcd = 7'h26;
    #1;
    check("lap_hold_sec", disp_sec, 7'h25);
    check("lap_hold_min", disp_min, 7'h01);
    step(); step(); step();
    check("lap_ticks", {6'd0, cnt_en}, 7'd1);
    press(2);
    check("unlap_state", {5'd0, state}, 7'd1);
    check("unlap_live", disp_sec, 7'h26);
    sec_bcd = 7'h27;
    #1;
    check("unlap_track", disp_sec, 7'h27);

    // 4: clr ignored in RUN; clr beats ss in PAUSE
    step();
    press(1);
    check("clr_in_run", {5'd0, state}, 7'd1);
    check("clr_in_run_pulse", {6'd0, cnt_clr}, 7'd0);
    step();
    press(0);
    check("pause2", {5'd0, state}, 7'd2);
    step();
    key_ss = 1'b1; key_clr = 1'b1;
    repeat (4) step();
    key_ss = 1'b0; key_clr = 1'b0;
    check("clr_wins", {5'd0, state}, 7'd0);
    check("clr_pulse", {6'd0, cnt_clr}, 7'd1);
    step();
    check("clr_pulse_end", {6'd0, cnt_clr}, 7'd0);
    check("ss_dropped", {5'd0, state}, 7'd0);

    // 5: restart from zeroed prescaler, wrap flag set and cleared
    step();
    press(0);
    check("run3", {5'd0, state}, 7'd1);
    step(); step();
    chain_co = 1'b1;
    step();
    check("zero_presc_t3", {6'd0, cnt_en}, 7'd0);
    check("ovf_needs_tick", {6'd0, ovf}, 7'd0);
    step();
    check("zero_presc_t4", {6'd0, cnt_en}, 7'd1);
    check("ovf_not_yet", {6'd0, ovf}, 7'd0);
    step();
    chain_co = 1'b0;
    check("ovf_set", {6'd0, ovf}, 7'd1);
    repeat (5) step();
    check("ovf_sticky", {6'd0, ovf}, 7'd1);
    press(0);
    check("pause3", {5'd0, state}, 7'd2);
    check("ovf_pause", {6'd0, ovf}, 7'd1);
    step();
    press(1);
    check("clr3_state", {5'd0, state}, 7'd0);
    check("ovf_cleared", {6'd0, ovf}, 7'd0);
    check("clr3_pulse", {6'd0, cnt_clr}, 7'd1);

    // 6: held key gives one transition; async reset mid-run
    step();
    key_ss = 1'b1;
    repeat (50) step();
    check("hold_one_edge", {5'd0, state}, 7'd1);
    key_ss = 1'b0;
    step(); step();
    check("pre_reset_tick", {6'd0, cnt_en}, 7'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_state", {5'd0, state}, 7'd0);
    check("async_cnt_en", {6'd0, cnt_en}, 7'd0);
    check("async_cnt_clr", {6'd0, cnt_clr}, 7'd0);
    check("async_ovf", {6'd0, ovf}, 7'd0);
    step();
    check("reset_held", {5'd0, state}, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
